forward_scoreboard: RTL and testbench
=====================================

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  XLEN, 32, datapath width
  RAW, 5, register address width (2**RAW architectural registers)
  NPORT, 2, number of source-operand read ports
  MUL_LAT, 4, multi-cycle multiply latency in cycles (2..7)
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  single clock, all state on rising edge
  rst_n  in  1  asynchronous, active-low reset
  id_valid  in  1  decode-stage instruction valid
  id_rs_addr  in  NPORT*RAW  source register addresses, port p at [p*RAW +: RAW]
  id_rs_data  in  NPORT*XLEN  register-file read data per port
  id_rd_addr  in  RAW  destination register
  id_rd_we  in  1  instruction writes rd
  id_is_load  in  1  instruction is a load
  id_is_mul  in  1  instruction is a multi-cycle multiply
  exmem_rd / exmem_we / exmem_result  in  RAW/1/XLEN  EX/MEM producer
  memwb_rd / memwb_we / memwb_result  in  RAW/1/XLEN  MEM/WB producer
  mul_rd / mul_we / mul_result  in  RAW/1/XLEN  multiplier completion
  fwd_data  out  NPORT*XLEN  forwarded operand per port
  fwd_sel  out  NPORT*2  per-port source: 00 regfile, 10 EX/MEM, 01 MEM/WB, 11 multiplier
  stall  out  1  hold decode stage this cycle
  stall_cnt  out  16  saturating count of stall cycles

Function
REQ-003 Scoreboard SHALL hold per register a 3-bit countdown cnt[r]; register r is pending when cnt[r] != 0.
REQ-004 Issue SHALL be accepted when id_valid=1 and stall=0; on acceptance with id_rd_we=1 and id_rd_addr!=0, cnt[rd] SHALL be loaded with MUL_LAT if id_is_mul, else 2 if id_is_load, else 1.
REQ-005 Every non-zero cnt[r] not being loaded that cycle SHALL decrement by 1 per clock; load on the same cycle SHALL take priority over decrement.
REQ-006 stall SHALL be combinational: 1 when id_valid=1 and any port p has id_rs_addr[p]!=0 and cnt[id_rs_addr[p]] > 1.
REQ-007 Register 0 SHALL never be pending; any port reading address 0 SHALL output fwd_data=0, fwd_sel=00.
REQ-008 Per-port source priority (combinational) SHALL be: multiplier (mul_we=1, mul_rd match) > EX/MEM (exmem_we=1, match) > MEM/WB (memwb_we=1, match) > id_rs_data.
REQ-009 fwd_data and fwd_sel SHALL be valid in the same cycle as their inputs (zero latency); forwarding SHALL be computed even when stall=1.
REQ-010 stall_cnt SHALL increment by 1 on each clock where stall=1, saturate at 16'hFFFF and never wrap.
REQ-011 A second issue to an already-pending rd SHALL overwrite cnt[rd] with the new instruction's latency (WAW: latest writer wins).
REQ-012 Unused/undriven decode inputs SHALL have no effect when id_valid=0; no scoreboard load occurs.

Reset
REQ-013 While rst_n=0, all cnt[r]=0 and stall_cnt=0 immediately, independent of clk.
REQ-014 Reset assertion mid-operation SHALL discard all pending entries; first cycle after deassertion, stall=0 for any id_valid input.
REQ-015 fwd_data/fwd_sel SHALL remain purely combinational functions of inputs during reset (no reset value beyond REQ-007 rules).

Verification
REQ-016 Bench SHALL cover:
  V1 ALU producer: issue rd=5 (ALU), next cycle read rs=5 with exmem_rd=5, exmem_we=1, exmem_result=0x1234 -> stall=0, fwd_data=0x1234, fwd_sel=10.
  V2 Load-use: issue load rd=3, next cycle read rs=3 -> stall=1 one cycle, stall_cnt=1; following cycle stall=0.
  V3 Multiply: issue mul rd=7 with MUL_LAT=4, read rs=7 each cycle -> stall=1 for 3 cycles, then with mul_rd=7, mul_we=1, mul_result=0xABCD -> fwd_sel=11, fwd_data=0xABCD.
  V4 Priority/x0: exmem and memwb both target rs=9 (0x11, 0x22) -> fwd_data=0x11; rs=0 with exmem_rd=0, exmem_we=1 -> fwd_data=0, fwd_sel=00.
  V5 WAW + reset: mul rd=4 then ALU rd=4 next cycle -> cnt[4]=1, no stall on rs=4 the cycle after; assert rst_n=0 mid-mul -> stall=0, stall_cnt=0 immediately.
  V6 Saturation: force 70000 consecutive stall cycles -> stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/forward_scoreboard.sv
// Operand forwarding plus per-register latency scoreboard for the decode stage.
// Generates decode stalls for load-use and multi-cycle multiply hazards.
module forward_scoreboard #(
  parameter int XLEN    = 32,
  parameter int RAW     = 5,
  parameter int NPORT   = 2,
  parameter int MUL_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [NPORT*RAW-1:0]  id_rs_addr,
  input  logic [NPORT*XLEN-1:0] id_rs_data,
  input  logic [RAW-1:0]        id_rd_addr,
  input  logic                  id_rd_we,
  input  logic                  id_is_load,
  input  logic                  id_is_mul,
  input  logic [RAW-1:0]        exmem_rd,
  input  logic                  exmem_we,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic [RAW-1:0]        memwb_rd,
  input  logic                  memwb_we,
  input  logic [XLEN-1:0]       memwb_result,
  input  logic [RAW-1:0]        mul_rd,
  input  logic                  mul_we,
  input  logic [XLEN-1:0]       mul_result,
  output logic [NPORT*XLEN-1:0] fwd_data,
  output logic [NPORT*2-1:0]    fwd_sel,
  output logic                  stall,
  output logic [15:0]           stall_cnt
);

  localparam int NREG = 1 << RAW;
  localparam logic [2:0] MUL_CNT = 3'(MUL_LAT);

  logic [2:0] cnt [NREG];
  logic       load_en;
  logic [2:0] load_val;

  always_comb begin
    stall = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      if (id_valid &&
          id_rs_addr[p*RAW +: RAW] != '0 &&
          cnt[id_rs_addr[p*RAW +: RAW]] > 3'd1)
        stall = 1'b1;
    end
  end

  always_comb begin
    load_en = id_valid && !stall && id_rd_we &&
              id_rd_addr != '0;
    if (id_is_mul)
      load_val = MUL_CNT;
    else if (id_is_load)
      load_val = 3'd2;
    else
      load_val = 3'd1;
  end

  // A new load wins over the countdown, so a WAW reissue simply overwrites.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (load_en && id_rd_addr == RAW'(r))
          cnt[r] <= load_val;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - 3'd1;
      end
    end
  end

  always_comb begin
    fwd_data = id_rs_data;
    fwd_sel  = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (id_rs_addr[p*RAW +: RAW] == '0) begin
        fwd_data[p*XLEN +: XLEN] = '0;
      end else if (mul_we &&
                   mul_rd == id_rs_addr[p*RAW +: RAW]) begin
        fwd_data[p*XLEN +: XLEN] = mul_result;
        fwd_sel[p*2 +: 2]        = 2'b11;
      end else if (exmem_we &&
                   exmem_rd == id_rs_addr[p*RAW +: RAW]) begin
        fwd_data[p*XLEN +: XLEN] = exmem_result;
        fwd_sel[p*2 +: 2]        = 2'b10;
      end else if (memwb_we &&
                   memwb_rd == id_rs_addr[p*RAW +: RAW]) begin
        fwd_data[p*XLEN +: XLEN] = memwb_result;
        fwd_sel[p*2 +: 2]        = 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard; driver queues expectations,
// a negedge monitor pops and compares them.
module tb_forward_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_rs_addr;
  logic [63:0] id_rs_data;
  logic [4:0]  id_rd_addr;
  logic        id_rd_we, id_is_load, id_is_mul;
  logic [4:0]  exmem_rd, memwb_rd, mul_rd;
  logic        exmem_we, memwb_we, mul_we;
  logic [31:0] exmem_result, memwb_result, mul_result;
  logic [63:0] fwd_data;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [15:0] stall_cnt;

  logic        s_valid;
  logic [9:0]  s_rs_addr;
  logic [4:0]  s_rd_addr;
  logic        s_rd_we, s_is_mul;
  logic [63:0] s_fwd_data;
  logic [3:0]  s_fwd_sel;
  logic        s_stall;
  logic [15:0] s_stall_cnt;

  always #5 clk = ~clk;

  forward_scoreboard #(.MUL_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rs_data(id_rs_data),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .id_is_mul(id_is_mul),
    .exmem_rd(exmem_rd), .exmem_we(exmem_we),
    .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_we(memwb_we),
    .memwb_result(memwb_result),
    .mul_rd(mul_rd), .mul_we(mul_we), .mul_result(mul_result),
    .fwd_data(fwd_data), .fwd_sel(fwd_sel),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  // Longest multiply latency keeps a held reader stalled 6 of every 7 cycles.
  forward_scoreboard #(.MUL_LAT(7)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(s_valid),
    .id_rs_addr(s_rs_addr), .id_rs_data(64'h0),
    .id_rd_addr(s_rd_addr), .id_rd_we(s_rd_we),
    .id_is_load(1'b0), .id_is_mul(s_is_mul),
    .exmem_rd(5'd0), .exmem_we(1'b0), .exmem_result(32'h0),
    .memwb_rd(5'd0), .memwb_we(1'b0), .memwb_result(32'h0),
    .mul_rd(5'd0), .mul_we(1'b0), .mul_result(32'h0),
    .fwd_data(s_fwd_data), .fwd_sel(s_fwd_sel),
    .stall(s_stall), .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    string       name;
    bit          sat;
    bit          c_stall;
    bit          stall;
    bit          c_fwd;
    int          port;
    logic [31:0] data;
    logic [1:0]  sel;
    bit          c_cnt;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  function automatic exp_t blank(string n);
    exp_t e;
    e.name = n; e.sat = 0; e.c_stall = 0; e.stall = 0;
    e.c_fwd = 0; e.port = 0; e.data = '0; e.sel = '0;
    e.c_cnt = 0; e.cnt = '0;
    return e;
  endfunction

  task automatic exp_stall(string n, bit s);
    exp_t e = blank(n);
    e.c_stall = 1; e.stall = s;
    q.push_back(e);
  endtask

  task automatic exp_cnt(string n, logic [15:0] c, bit sat);
    exp_t e = blank(n);
    e.c_cnt = 1; e.cnt = c; e.sat = sat;
    q.push_back(e);
  endtask

  task automatic exp_fwd(string n, int p, logic [31:0] d,
                         logic [1:0] s);
    exp_t e = blank(n);
    e.c_fwd = 1; e.port = p; e.data = d; e.sel = s;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] d;
      logic [1:0]  s;
      logic [15:0] c;
      e = q.pop_front();
      if (e.c_stall) begin
        checks++;
        if (stall !== e.stall) begin
          failures++;
          $display("FAIL %s stall got=%b exp=%b",
                   e.name, stall, e.stall);
        end
      end
      if (e.c_fwd) begin
        d = fwd_data[e.port*32 +: 32];
        s = fwd_sel[e.port*2 +: 2];
        checks++;
        if (d !== e.data || s !== e.sel) begin
          failures++;
          $display("FAIL %s fwd p%0d got=%h/%b exp=%h/%b",
                   e.name, e.port, d, s, e.data, e.sel);
        end
      end
      if (e.c_cnt) begin
        c = e.sat ? s_stall_cnt : stall_cnt;
        checks++;
        if (c !== e.cnt) begin
          failures++;
          $display("FAIL %s stall_cnt got=%h exp=%h",
                   e.name, c, e.cnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs_addr = '0;
    id_rs_data = {32'hBBBB_0001, 32'hAAAA_0000};
    id_rd_addr = '0; id_rd_we = 0;
    id_is_load = 0; id_is_mul = 0;
    exmem_rd = '0; exmem_we = 0; exmem_result = '0;
    memwb_rd = '0; memwb_we = 0; memwb_result = '0;
    mul_rd = '0; mul_we = 0; mul_result = '0;
  endtask

  task automatic issue(logic [4:0] rd, bit ld, bit mul);
    idle();
    id_valid = 1; id_rd_addr = rd; id_rd_we = 1;
    id_is_load = ld; id_is_mul = mul;
  endtask

  task automatic read(logic [4:0] rs0, logic [4:0] rs1);
    idle();
    id_valid = 1; id_rs_addr = {rs1, rs0};
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    s_valid = 0; s_rs_addr = '0; s_rd_addr = '0;
    s_rd_we = 0; s_is_mul = 0;
    rst_n = 0;
    #12;
    exp_cnt("reset_cnt", 16'h0, 0);
    exp_stall("reset_stall", 0);
    tick();
    rst_n = 1;

    // V1 ALU producer forwarded from EX/MEM
    tick(); issue(5, 0, 0);
    exp_stall("v1_issue", 0);
    tick(); read(5, 0);
    exmem_rd = 5; exmem_we = 1; exmem_result = 32'h1234;
    exp_stall("v1_stall", 0);
    exp_fwd("v1_fwd", 0, 32'h1234, 2'b10);
    exp_fwd("v1_p1_x0", 1, 32'h0, 2'b00);

    // V2 load-use
    tick(); issue(3, 1, 0);
    exp_stall("v2_issue", 0);
    tick(); read(3, 0);
    exp_stall("v2_stall", 1);
    exp_cnt("v2_cnt0", 16'd0, 0);
    tick();
    exp_stall("v2_release", 0);
    exp_cnt("v2_cnt1", 16'd1, 0);

    // V3 multiply: three stall cycles then mul forward
    tick(); issue(7, 0, 1);
    exp_stall("v3_issue", 0);
    tick(); read(7, 0);
    exp_stall("v3_s1", 1);
    tick(); exp_stall("v3_s2", 1);
    tick(); exp_stall("v3_s3", 1);
    tick();
    mul_rd = 7; mul_we = 1; mul_result = 32'hABCD;
    exp_stall("v3_done", 0);
    exp_fwd("v3_fwd", 0, 32'hABCD, 2'b11);
    exp_cnt("v3_cnt", 16'd4, 0);

    // V4 priority and x0
    tick(); read(9, 9);
    exmem_rd = 9; exmem_we = 1; exmem_result = 32'h11;
    memwb_rd = 9; memwb_we = 1; memwb_result = 32'h22;
    exp_fwd("v4_ex_over_wb", 0, 32'h11, 2'b10);
    exp_fwd("v4_ex_over_wb_p1", 1, 32'h11, 2'b10);
    tick(); read(9, 10);
    exmem_rd = 10; exmem_we = 1; exmem_result = 32'h11;
    memwb_rd = 9; memwb_we = 1; memwb_result = 32'h22;
    mul_rd = 10; mul_we = 1; mul_result = 32'h33;
    exp_fwd("v4_memwb", 0, 32'h22, 2'b01);
    exp_fwd("v4_mul_over_ex", 1, 32'h33, 2'b11);
    tick(); read(0, 12);
    exmem_rd = 0; exmem_we = 1; exmem_result = 32'h55;
    memwb_rd = 12; memwb_we = 0; memwb_result = 32'h66;
    exp_fwd("v4_x0", 0, 32'h0, 2'b00);
    exp_fwd("v4_regfile", 1, 32'hBBBB_0001, 2'b00);

    // id_valid=0 must not load the scoreboard
    tick(); issue(6, 0, 1); id_valid = 0;
    tick(); read(6, 0);
    exp_stall("novalid_noload", 0);

    // V5 WAW then async reset mid-multiply
    tick(); issue(4, 0, 1);
    tick(); issue(4, 0, 0);
    exp_stall("v5_waw_issue", 0);
    tick(); read(4, 0);
    exp_stall("v5_waw", 0);
    tick(); issue(4, 0, 1);
    tick(); read(4, 0);
    exp_stall("v5_mul_pend", 1);
    exp_cnt("v5_cnt_pre", 16'd4, 0);
    tick();
    rst_n = 0;
    #1;
    exp_stall("v5_rst_stall", 0);
    exp_cnt("v5_rst_cnt", 16'd0, 0);
    tick();
    rst_n = 1;
    exp_stall("v5_post_rst", 0);
    tick();
    exp_stall("v5_post_rst2", 0);
    exp_cnt("v5_post_cnt", 16'd0, 0);

    // V6 saturation: held mul reader on the MUL_LAT=7 instance
    tick(); idle();
    s_valid = 1; s_rs_addr = {5'd0, 5'd1};
    s_rd_addr = 1; s_rd_we = 1; s_is_mul = 1;
    repeat (82000) @(posedge clk);
    #1;
    exp_cnt("v6_sat", 16'hFFFF, 1);
    tick();
    exp_cnt("v6_sat_hold", 16'hFFFF, 1);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
